gpio_serial_cfg_bank: RTL and testbench
=======================================

// Module: gpio_serial_cfg_bank
// PURPOSE
//  Parametrised GPIO-driven serial configuration bank for the PL. The PS bit-bangs a
//  shared sdata line plus per-register serial clocks into shared shadow registers.
//  A commit strobe copies loaded shadows into per-channel active registers for every
//  channel set in a one-hot channel-select register.
//  Sits between the PS GPIO bus and the DAC/ADC channel controllers. Adds
//  synchronisation, load-length checking and atomic multi-channel commit.
// PARAMETERS
//  NUM_CH       8   channels; width of one-hot select; number of active register sets
//  NUM_REGS     4   config registers per channel (run cycles, pre/post delay, ...)
//  REG_W        32  bits per config register
//  GPIO_W       16  GPIO bus width; elaboration error unless NUM_REGS+3 <= GPIO_W
//  SYNC_STAGES  2   synchroniser flops per GPIO line (>=2)
// PORTS
//  clk          in   1                    fabric clock
//  rstn         in   1                    synchronous reset, active low
//  gpio_in      in   GPIO_W               async PS GPIO: [0]=sdata, [1]=chan_sel clk,
//                                         [2+r]=reg r clk, [NUM_REGS+2]=commit
//  chan_sel     out  NUM_CH               current channel-select shift register
//  cfg_out      out  NUM_CH*NUM_REGS*REG_W active regs; ch c, reg r at [(c*NUM_REGS+r)*REG_W +: REG_W]
//  commit_pulse out  NUM_CH               1-cycle pulse on channels updated by a commit
//  cfg_err      out  1                    sticky: commit saw a partially loaded shadow
// BEHAVIOUR
//  - Reset (rstn=0 at clk edge): all outputs, shadows, counters, dirty bits and sync flops -> 0.
//  - Synchronise every gpio_in bit through SYNC_STAGES flops. Rising edge = sync_out & ~prev.
//  - Post-reset arm counter: edges ignored for SYNC_STAGES+1 cycles after rstn rises.
//    A line held high across reset therefore never creates a spurious edge.
//  - Latency: GPIO transition -> register update exactly SYNC_STAGES+1 clk cycles.
//  - chan_sel clk edge: chan_sel <= {chan_sel[NUM_CH-2:0], sdata_sync} (MSB-first load).
//  - reg r clk edge: shadow[r] <= {shadow[r][REG_W-2:0], sdata_sync}.
//    Also dirty[r] <= 1 and cnt[r] <= sat(cnt[r]+1); cnt saturates at REG_W+1.
//  - Multiple serial clk edges in one cycle: each addressed register shifts the same sdata bit.
//  - Commit edge: for each r with dirty[r]:
//      cnt[r]==REG_W -> copy shadow[r] to active[c][r] for every c with chan_sel[c]=1.
//      otherwise    -> no copy, cfg_err <= 1.
//    Then clear all dirty[r] and cnt[r]. Shadows keep their contents.
//    commit_pulse <= chan_sel on that cycle, even if no register was dirty; 0 otherwise.
//  - chan_sel==0 at commit: nothing copied, commit_pulse=0, counters still cleared.
//  - Commit and chan_sel edge in the same cycle: commit uses the pre-shift chan_sel.
//  - Commit and reg r edge in the same cycle: commit uses pre-shift shadow/cnt.
//    The shift is still applied, and leaves dirty[r]=1, cnt[r]=1 (first bit of next load).
//  - cfg_err clears only on reset. Active regs change only on commit or reset.
// TESTING
//  1 Reset with all gpio_in=1, release -> no shift/commit for 50 cycles, outputs all 0.
//  2 Shift chan_sel=8'h05, load reg1=32'hDEADBEEF, commit ->
//    ch0/ch2 reg1=DEADBEEF, others 0; commit_pulse=8'h05 for 1 cycle, exactly SYNC_STAGES+1 after commit edge.
//  3 Load reg0 with 31 bits, commit -> cfg_err=1, no active reg changes, cnt cleared.
//    Reload 32 bits and commit -> copy happens, cfg_err stays 1.
//  4 Load reg2 with 40 bits (last 32 = 32'h0000_1234), commit -> cfg_err=1, reg2 unchanged.
//  5 Commit edge coincident with chan_sel shift (old 8'h01, new 8'h02) -> only ch0 updated.
//    Next commit -> ch1 updated.
//  6 Assert rstn=0 mid-load (16 bits shifted), release, load full 32'hA5A5A5A5, commit ->
//    correct value, cfg_err=0.

Source files
------------

// File: rtl/gpio_serial_cfg_bank_if.sv
// PS GPIO side of the serial configuration bank: raw GPIO lines in, channel select,
// active configuration registers and commit status out.
interface gpio_serial_cfg_bank_if #(
    parameter int NUM_CH   = 8,
    parameter int NUM_REGS = 4,
    parameter int REG_W    = 32,
    parameter int GPIO_W   = 16
) ();
    logic [GPIO_W-1:0]                gpio_in;
    logic [NUM_CH-1:0]                chan_sel;
    logic [NUM_CH*NUM_REGS*REG_W-1:0] cfg_out;
    logic [NUM_CH-1:0]                commit_pulse;
    logic                             cfg_err;

    modport master (
        output gpio_in,
        input  chan_sel,
        input  cfg_out,
        input  commit_pulse,
        input  cfg_err
    );

    modport slave (
        input  gpio_in,
        output chan_sel,
        output cfg_out,
        output commit_pulse,
        output cfg_err
    );
endinterface

// File: rtl/gpio_serial_cfg_bank.sv
// GPIO bit-banged configuration bank: synchronised serial loads into shared shadows,
// length-checked atomic commit into the active registers of every selected channel.
module gpio_serial_cfg_bank #(
    parameter int NUM_CH      = 8,
    parameter int NUM_REGS    = 4,
    parameter int REG_W       = 32,
    parameter int GPIO_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    gpio_serial_cfg_bank_if.slave bus
);
    localparam int NUM_LINES   = NUM_REGS + 3;
    localparam int SDATA_LINE  = 0;
    localparam int CS_LINE     = 1;
    localparam int COMMIT_LINE = NUM_REGS + 2;
    localparam int CW          = $clog2(REG_W + 2);
    localparam int AW          = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(REG_W);
    localparam logic [CW-1:0] CNT_SAT  = CW'(REG_W + 1);
    localparam logic [AW-1:0] ARM_DONE = AW'(SYNC_STAGES + 1);

    if (NUM_REGS + 3 > GPIO_W) begin : g_gpio_too_narrow
        $error("gpio_serial_cfg_bank: GPIO_W must be at least NUM_REGS+3");
    end
    if (SYNC_STAGES < 2) begin : g_sync_too_short
        $error("gpio_serial_cfg_bank: SYNC_STAGES must be at least 2");
    end
    if (NUM_CH < 2) begin : g_too_few_channels
        $error("gpio_serial_cfg_bank: NUM_CH must be at least 2");
    end
    if (GPIO_W > NUM_LINES) begin : g_spare_gpio
        logic unused_gpio;
        assign unused_gpio = ^bus.gpio_in[GPIO_W-1:NUM_LINES];
    end

    logic [NUM_LINES-1:0] sync_q [SYNC_STAGES];
    logic [NUM_LINES-1:0] sync_prev;
    logic [NUM_LINES-1:0] rise;
    logic [AW-1:0]        arm_cnt;
    logic                 armed;

    logic                sdata;
    logic                cs_edge;
    logic                commit_edge;
    logic [NUM_REGS-1:0] reg_edge;

    logic [NUM_CH-1:0]   chan_sel_q;
    logic [NUM_CH-1:0]   commit_pulse_q;
    logic                cfg_err_q;
    logic [REG_W-1:0]    shadow [NUM_REGS];
    logic [CW-1:0]       cnt    [NUM_REGS];
    logic [NUM_REGS-1:0] dirty;
    logic [REG_W-1:0]    active [NUM_CH][NUM_REGS];
    logic [NUM_CH*NUM_REGS*REG_W-1:0] cfg_flat;

    // Lines held high through reset would look like rising edges once the
    // synchroniser fills, so edges stay masked until the pipeline has settled.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            sync_prev <= '0;
            arm_cnt   <= '0;
        end else begin
            sync_q[0] <= bus.gpio_in[NUM_LINES-1:0];
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            sync_prev <= sync_q[SYNC_STAGES-1];
            if (!armed) begin
                arm_cnt <= arm_cnt + 1'b1;
            end
        end
    end

    assign armed       = (arm_cnt == ARM_DONE);
    assign rise        = sync_q[SYNC_STAGES-1] & ~sync_prev & {NUM_LINES{armed}};
    assign sdata       = sync_q[SYNC_STAGES-1][SDATA_LINE];
    assign cs_edge     = rise[CS_LINE];
    assign commit_edge = rise[COMMIT_LINE];
    assign reg_edge    = rise[2 +: NUM_REGS];

    // A commit always sees the pre-shift chan_sel, shadow and counter; a load edge in
    // the same cycle still shifts and starts a fresh count at one.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            chan_sel_q     <= '0;
            commit_pulse_q <= '0;
            cfg_err_q      <= 1'b0;
            dirty          <= '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                shadow[r] <= '0;
                cnt[r]    <= '0;
                for (int c = 0; c < NUM_CH; c++) begin
                    active[c][r] <= '0;
                end
            end
        end else begin
            commit_pulse_q <= commit_edge ? chan_sel_q : '0;
            if (cs_edge) begin
                chan_sel_q <= {chan_sel_q[NUM_CH-2:0], sdata};
            end
            for (int r = 0; r < NUM_REGS; r++) begin
                if (commit_edge && dirty[r]) begin
                    if (cnt[r] == CNT_FULL) begin
                        for (int c = 0; c < NUM_CH; c++) begin
                            if (chan_sel_q[c]) begin
                                active[c][r] <= shadow[r];
                            end
                        end
                    end else begin
                        cfg_err_q <= 1'b1;
                    end
                end
                if (reg_edge[r]) begin
                    shadow[r] <= {shadow[r][REG_W-2:0], sdata};
                    dirty[r]  <= 1'b1;
                    if (commit_edge) begin
                        cnt[r] <= CW'(1);
                    end else if (cnt[r] != CNT_SAT) begin
                        cnt[r] <= cnt[r] + 1'b1;
                    end
                end else if (commit_edge) begin
                    dirty[r] <= 1'b0;
                    cnt[r]   <= '0;
                end
            end
        end
    end

    always_comb begin
        cfg_flat = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cfg_flat[(c*NUM_REGS+r)*REG_W +: REG_W] = active[c][r];
            end
        end
    end

    assign bus.chan_sel     = chan_sel_q;
    assign bus.cfg_out      = cfg_flat;
    assign bus.commit_pulse = commit_pulse_q;
    assign bus.cfg_err      = cfg_err_q;
endmodule

// File: tb/tb_gpio_serial_cfg_bank.sv
// Self-checking bench for gpio_serial_cfg_bank: a behavioural model predicts each commit,
// a scoreboard compares it against the DUT when the pulse is due.
module tb_gpio_serial_cfg_bank;
    localparam int NUM_CH      = 8;
    localparam int NUM_REGS    = 4;
    localparam int REG_W       = 32;
    localparam int GPIO_W      = 16;
    localparam int SYNC_STAGES = 2;
    localparam int LAT         = SYNC_STAGES + 1;
    localparam int CS_LINE     = 1;
    localparam int COMMIT_LINE = NUM_REGS + 2;
    localparam int CFG_W       = NUM_CH * NUM_REGS * REG_W;

    logic clk = 1'b0;
    logic rstn;

    gpio_serial_cfg_bank_if #(
        .NUM_CH(NUM_CH), .NUM_REGS(NUM_REGS), .REG_W(REG_W), .GPIO_W(GPIO_W)
    ) bus ();

    gpio_serial_cfg_bank #(
        .NUM_CH(NUM_CH), .NUM_REGS(NUM_REGS), .REG_W(REG_W),
        .GPIO_W(GPIO_W), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int checks   = 0;
    int failures = 0;

    logic [REG_W-1:0]  m_shadow [NUM_REGS];
    int                m_cnt    [NUM_REGS];
    bit                m_dirty  [NUM_REGS];
    logic [REG_W-1:0]  m_active [NUM_CH][NUM_REGS];
    logic [NUM_CH-1:0] m_cs;
    logic              m_err;

    typedef struct {
        int                due;
        logic [NUM_CH-1:0] pulse;
        logic [CFG_W-1:0]  cfg;
        logic              err;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;
    bit   mon_found;

    function automatic logic [CFG_W-1:0] model_flat();
        logic [CFG_W-1:0] f;
        f = '0;
        for (int c = 0; c < NUM_CH; c++)
            for (int r = 0; r < NUM_REGS; r++)
                f[(c*NUM_REGS+r)*REG_W +: REG_W] = m_active[c][r];
        return f;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NUM_REGS; r++) begin
            m_shadow[r] = '0;
            m_cnt[r]    = 0;
            m_dirty[r]  = 1'b0;
            for (int c = 0; c < NUM_CH; c++) m_active[c][r] = '0;
        end
        m_cs  = '0;
        m_err = 1'b0;
    endtask

    task automatic model_shift_reg(input int r, input bit b);
        m_shadow[r] = {m_shadow[r][REG_W-2:0], b};
        m_dirty[r]  = 1'b1;
        if (m_cnt[r] < REG_W + 1) m_cnt[r] = m_cnt[r] + 1;
    endtask

    // Applies one commit to the model and queues what the DUT must show LAT cycles later.
    task automatic model_commit();
        exp_t e;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (m_dirty[r]) begin
                if (m_cnt[r] == REG_W) begin
                    for (int c = 0; c < NUM_CH; c++)
                        if (m_cs[c]) m_active[c][r] = m_shadow[r];
                end else begin
                    m_err = 1'b1;
                end
            end
            m_dirty[r] = 1'b0;
            m_cnt[r]   = 0;
        end
        e.due   = cycle + LAT;
        e.pulse = m_cs;
        e.cfg   = model_flat();
        e.err   = m_err;
        sb_q.push_back(e);
    endtask

    task automatic send_bit(input int line, input bit b);
        @(posedge clk); #1;
        bus.gpio_in[0] = b;
        @(posedge clk); #1;
        bus.gpio_in[line] = 1'b1;
        if (line == CS_LINE) m_cs = {m_cs[NUM_CH-2:0], b};
        else model_shift_reg(line - 2, b);
        @(posedge clk); #1;
        bus.gpio_in[line] = 1'b0;
    endtask

    task automatic load_cs(input logic [NUM_CH-1:0] v);
        for (int i = NUM_CH - 1; i >= 0; i--) send_bit(CS_LINE, v[i]);
    endtask

    task automatic load_reg(input int r, input logic [63:0] v, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) send_bit(2 + r, v[i]);
    endtask

    task automatic commit();
        @(posedge clk); #1;
        model_commit();
        bus.gpio_in[COMMIT_LINE] = 1'b1;
        @(posedge clk); #1;
        bus.gpio_in[COMMIT_LINE] = 1'b0;
        repeat (LAT + 2) @(posedge clk);
    endtask

    // Commit edge and a serial clock edge on 'line' in the very same cycle.
    task automatic commit_with(input int line, input bit b);
        @(posedge clk); #1;
        bus.gpio_in[0] = b;
        @(posedge clk); #1;
        model_commit();
        if (line == CS_LINE) m_cs = {m_cs[NUM_CH-2:0], b};
        else model_shift_reg(line - 2, b);
        bus.gpio_in[COMMIT_LINE] = 1'b1;
        bus.gpio_in[line]        = 1'b1;
        @(posedge clk); #1;
        bus.gpio_in[COMMIT_LINE] = 1'b0;
        bus.gpio_in[line]        = 1'b0;
        repeat (LAT + 2) @(posedge clk);
    endtask

    task automatic hard_reset();
        @(posedge clk); #1;
        bus.gpio_in = '0;
        rstn        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
        repeat (LAT + 3) @(posedge clk);
    endtask

    // Scoreboard side: pop the expected commit when it is due, otherwise no pulse allowed.
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (sb_q.size() != 0 && sb_q[0].due == cycle) begin
                mon_e = sb_q.pop_front();
                checks++;
                if (bus.commit_pulse !== mon_e.pulse) begin
                    failures++;
                    $display("[TB] FAIL commit_pulse cycle=%0d actual=%h expected=%h",
                             cycle, bus.commit_pulse, mon_e.pulse);
                end
                checks++;
                if (bus.cfg_out !== mon_e.cfg) begin
                    failures++;
                    mon_found = 1'b0;
                    for (int k = 0; k < NUM_CH * NUM_REGS; k++) begin
                        if (!mon_found && bus.cfg_out[k*REG_W +: REG_W] !== mon_e.cfg[k*REG_W +: REG_W]) begin
                            mon_found = 1'b1;
                            $display("[TB] FAIL cfg_out cycle=%0d ch=%0d reg=%0d actual=%h expected=%h",
                                     cycle, k / NUM_REGS, k % NUM_REGS,
                                     bus.cfg_out[k*REG_W +: REG_W], mon_e.cfg[k*REG_W +: REG_W]);
                        end
                    end
                end
                checks++;
                if (bus.cfg_err !== mon_e.err) begin
                    failures++;
                    $display("[TB] FAIL cfg_err_at_commit cycle=%0d actual=%b expected=%b",
                             cycle, bus.cfg_err, mon_e.err);
                end
            end else begin
                checks++;
                if (bus.commit_pulse !== '0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_pulse cycle=%0d actual=%h expected=00",
                             cycle, bus.commit_pulse);
                end
            end
        end
    end

    task automatic test_reset();
        bus.gpio_in = '1;
        rstn        = 1'b0;
        model_reset();
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.chan_sel !== '0) begin failures++; $display("[TB] FAIL reset_chan_sel actual=%h expected=00", bus.chan_sel); end
        checks++;
        if (bus.cfg_out !== '0) begin failures++; $display("[TB] FAIL reset_cfg_out actual_nonzero expected=0"); end
        checks++;
        if (bus.commit_pulse !== '0) begin failures++; $display("[TB] FAIL reset_pulse actual=%h expected=00", bus.commit_pulse); end
        checks++;
        if (bus.cfg_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_cfg_err actual=%b expected=0", bus.cfg_err); end
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (50) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.chan_sel !== '0) begin failures++; $display("[TB] FAIL held_high_chan_sel actual=%h expected=00", bus.chan_sel); end
        checks++;
        if (bus.cfg_out !== '0) begin failures++; $display("[TB] FAIL held_high_cfg_out actual_nonzero expected=0"); end
        checks++;
        if (bus.cfg_err !== 1'b0) begin failures++; $display("[TB] FAIL held_high_cfg_err actual=%b expected=0", bus.cfg_err); end
        @(posedge clk); #1;
        bus.gpio_in = '0;
        repeat (LAT + 2) @(posedge clk);
    endtask

    task automatic test_basic_commit();
        load_cs(8'h05);
        repeat (LAT + 1) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.chan_sel !== 8'h05) begin failures++; $display("[TB] FAIL chan_sel_load actual=%h expected=05", bus.chan_sel); end
        load_reg(1, 64'hDEADBEEF, 32);
        commit();
        checks++;
        if (bus.cfg_out[(2*NUM_REGS+1)*REG_W +: REG_W] !== 32'hDEADBEEF) begin
            failures++;
            $display("[TB] FAIL ch2_reg1 actual=%h expected=deadbeef", bus.cfg_out[(2*NUM_REGS+1)*REG_W +: REG_W]);
        end
    endtask

    task automatic test_short_load();
        load_reg(0, 64'h2468ACE1, 31);
        commit();
        checks++;
        if (bus.cfg_err !== 1'b1) begin failures++; $display("[TB] FAIL short_load_err actual=%b expected=1", bus.cfg_err); end
        load_reg(0, 64'h13579BDF, 32);
        commit();
        checks++;
        if (bus.cfg_out[(2*NUM_REGS+0)*REG_W +: REG_W] !== 32'h13579BDF) begin
            failures++;
            $display("[TB] FAIL reload_ch2_reg0 actual=%h expected=13579bdf", bus.cfg_out[(2*NUM_REGS+0)*REG_W +: REG_W]);
        end
    endtask

    task automatic test_long_load();
        hard_reset();
        load_reg(2, 64'h11111111, 32);
        commit();
        load_cs(8'h05);
        load_reg(2, 64'hCAFEF00D, 32);
        commit();
        checks++;
        if (bus.cfg_err !== 1'b0) begin failures++; $display("[TB] FAIL full_load_err actual=%b expected=0", bus.cfg_err); end
        load_reg(2, 64'h00AB_0000_1234, 40);
        commit();
        checks++;
        if (bus.cfg_err !== 1'b1) begin failures++; $display("[TB] FAIL long_load_err actual=%b expected=1", bus.cfg_err); end
        checks++;
        if (bus.cfg_out[(0*NUM_REGS+2)*REG_W +: REG_W] !== 32'hCAFEF00D) begin
            failures++;
            $display("[TB] FAIL long_load_ch0_reg2 actual=%h expected=cafef00d", bus.cfg_out[(0*NUM_REGS+2)*REG_W +: REG_W]);
        end
    endtask

    task automatic test_commit_cs_overlap();
        load_cs(8'h01);
        load_reg(3, 64'h0BADF00D, 32);
        commit_with(CS_LINE, 1'b0);
        checks++;
        if (bus.chan_sel !== 8'h02) begin failures++; $display("[TB] FAIL overlap_chan_sel actual=%h expected=02", bus.chan_sel); end
        load_reg(3, 64'h600DF00D, 32);
        commit();
        checks++;
        if (bus.cfg_out[(1*NUM_REGS+3)*REG_W +: REG_W] !== 32'h600DF00D) begin
            failures++;
            $display("[TB] FAIL overlap_ch1_reg3 actual=%h expected=600df00d", bus.cfg_out[(1*NUM_REGS+3)*REG_W +: REG_W]);
        end
    endtask

    task automatic test_back_to_back();
        load_reg(0, 64'hFEEDC0DE, 32);
        commit_with(2, 1'b1);
        load_reg(0, 64'h3C3C3C3C, 31);
        commit();
        checks++;
        if (bus.cfg_out[(1*NUM_REGS+0)*REG_W +: REG_W] !== 32'hBC3C3C3C) begin
            failures++;
            $display("[TB] FAIL b2b_ch1_reg0 actual=%h expected=bc3c3c3c", bus.cfg_out[(1*NUM_REGS+0)*REG_W +: REG_W]);
        end
    endtask

    task automatic test_reset_mid_load();
        load_cs(8'h81);
        load_reg(0, 64'hFFFF, 16);
        hard_reset();
        load_cs(8'h81);
        load_reg(0, 64'hA5A5A5A5, 32);
        commit();
        checks++;
        if (bus.cfg_err !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_err actual=%b expected=0", bus.cfg_err); end
        checks++;
        if (bus.cfg_out[(7*NUM_REGS+0)*REG_W +: REG_W] !== 32'hA5A5A5A5) begin
            failures++;
            $display("[TB] FAIL mid_reset_ch7_reg0 actual=%h expected=a5a5a5a5", bus.cfg_out[(7*NUM_REGS+0)*REG_W +: REG_W]);
        end
    endtask

    initial begin
        bus.gpio_in = '1;
        rstn        = 1'b0;
        model_reset();
        $display("[TB] starting");
        test_reset();
        test_basic_commit();
        test_short_load();
        test_long_load();
        test_commit_cs_overlap();
        test_back_to_back();
        test_reset_mid_load();
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
